sa_tile_sequencer: RTL and testbench

// Sequences the ternary systolic array for one job: loads the weight set once,

---
 rtl/sa_pkg.sv | 22 ++
 rtl/sa_tile_sequencer_if.sv | 28 ++
 rtl/sa_step_counter.sv | 20 ++
 rtl/sa_tile_sequencer.sv | 100 ++++++++++
 tb/tb_sa_tile_sequencer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: state type, feed/stream cycle counts and width helpers for the tile sequencer
package sa_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_HIDDEN = 4;
  localparam int DEF_CONTEXT = 4;
  localparam int DEF_MAX_TILES = 16;
  typedef enum logic [2:0] {IDLE, LOAD_W, CLEAR, STREAM, OUTPUT, DONE} state_t;
  function automatic int feed_cycles(input int h, input int c);
    return h + c - 1;
  endfunction
  function automatic int stream_cycles(input int h, input int c);
    return feed_cycles(h, c) + h - 1;
  endfunction
  function automatic int tile_w(input int m);
    return $clog2(m + 1);
  endfunction
  function automatic int step_w(input int s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction
  localparam int DEF_TW = tile_w(DEF_MAX_TILES);
  localparam int DEF_SW = step_w(stream_cycles(DEF_HIDDEN, DEF_CONTEXT));
endpackage

// File: rtl/sa_tile_sequencer_if.sv
// sa_tile_sequencer_if: job start, array strobes and result handshake; master = sequencer, slave = front-end/array/consumer
interface sa_tile_sequencer_if import sa_pkg::*; #(
  parameter int TW = DEF_TW,
  parameter int SW = DEF_SW
);
  logic          start_valid;
  logic          start_ready;
  logic [TW-1:0] num_tiles;
  logic          abort;
  logic          w_load;
  logic          sa_clear;
  logic          sa_en;
  logic          x_valid;
  logic [SW-1:0] x_step;
  logic [TW-1:0] tile_idx;
  logic          y_valid;
  logic          y_ready;
  logic          busy;
  logic          done;
  modport master (
    input  start_valid, num_tiles, abort, y_ready,
    output start_ready, w_load, sa_clear, sa_en, x_valid, x_step, tile_idx, y_valid, busy, done
  );
  modport slave (
    output start_valid, num_tiles, abort, y_ready,
    input  start_ready, w_load, sa_clear, sa_en, x_valid, x_step, tile_idx, y_valid, busy, done
  );
endinterface

// File: rtl/sa_step_counter.sv
// sa_step_counter: loadable up-counter (load clears, en advances) with terminal count tc at LAST
module sa_step_counter #(
  parameter int SW = 4,
  parameter int LAST = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          en,
  output logic [SW-1:0] cnt,
  output logic          tc
);
  logic [SW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
  assign tc = cnt_q == SW'(LAST);
endmodule

// File: rtl/sa_tile_sequencer.sv
// sa_tile_sequencer: loads weights once, then clears/streams/outputs num_tiles tiles through the array (clk, rst_n, bus.master)
module sa_tile_sequencer import sa_pkg::*; #(
  parameter int HIDDEN_SIZE = DEF_HIDDEN,
  parameter int CONTEXT_LENGTH = DEF_CONTEXT,
  parameter int MAX_TILES = DEF_MAX_TILES
) (
  input logic clk,
  input logic rst_n,
  sa_tile_sequencer_if.master bus
);
  localparam int FEED = feed_cycles(HIDDEN_SIZE, CONTEXT_LENGTH);
  localparam int STREAMC = stream_cycles(HIDDEN_SIZE, CONTEXT_LENGTH);
  localparam int TW = tile_w(MAX_TILES);
  localparam int SW = step_w(STREAMC);
  state_t state_q, state_d;
  logic [TW-1:0] tiles_q, tiles_d, tile_q, tile_d;
  logic start_ready_q, start_ready_d, busy_q, busy_d, w_load_q, w_load_d, sa_clear_q, sa_clear_d;
  logic sa_en_q, sa_en_d, x_valid_q, x_valid_d, y_valid_q, y_valid_d, done_q, done_d;
  logic [SW-1:0] step;
  logic [SW:0] step_nxt;
  logic step_tc, more;
  // Counter is held at 0 outside STREAM so an abort or tile exit always leaves x_step clean.
  sa_step_counter #(.SW(SW), .LAST(STREAMC - 1)) u_step (
    .clk(clk),
    .rst_n(rst_n),
    .load(state_d != STREAM),
    .en(state_q == STREAM),
    .cnt(step),
    .tc(step_tc)
  );
  always_comb begin
    state_d = state_q;
    tiles_d = tiles_q;
    tile_d = tile_q;
    more = ({1'b0, tile_q} + 1'b1) < {1'b0, tiles_q};
    unique case (state_q)
      IDLE: if (bus.start_valid) begin
        state_d = (bus.num_tiles == '0) ? DONE : LOAD_W;
        tiles_d = (bus.num_tiles > TW'(MAX_TILES)) ? TW'(MAX_TILES) : bus.num_tiles;
      end
      LOAD_W: state_d = CLEAR;
      CLEAR: state_d = STREAM;
      STREAM: state_d = step_tc ? OUTPUT : STREAM;
      OUTPUT: if (bus.y_ready) begin
        state_d = more ? CLEAR : DONE;
        tile_d = more ? tile_q + 1'b1 : tile_q;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) state_d = IDLE;
    if (state_d == IDLE) tile_d = '0;
    // Outputs are registered from the next state, so x_valid needs the step value of the next cycle.
    step_nxt = (state_q == STREAM) ? {1'b0, step} + 1'b1 : '0;
    start_ready_d = state_d == IDLE;
    busy_d = state_d != IDLE;
    w_load_d = state_d == LOAD_W;
    sa_clear_d = state_d == CLEAR;
    sa_en_d = state_d == STREAM;
    x_valid_d = state_d == STREAM && step_nxt < (SW + 1)'(FEED);
    y_valid_d = state_d == OUTPUT;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      tiles_q <= '0;
      tile_q <= '0;
      start_ready_q <= 1'b1;
      busy_q <= 1'b0;
      w_load_q <= 1'b0;
      sa_clear_q <= 1'b0;
      sa_en_q <= 1'b0;
      x_valid_q <= 1'b0;
      y_valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tiles_q <= tiles_d;
      tile_q <= tile_d;
      start_ready_q <= start_ready_d;
      busy_q <= busy_d;
      w_load_q <= w_load_d;
      sa_clear_q <= sa_clear_d;
      sa_en_q <= sa_en_d;
      x_valid_q <= x_valid_d;
      y_valid_q <= y_valid_d;
      done_q <= done_d;
    end
  assign bus.start_ready = start_ready_q;
  assign bus.busy = busy_q;
  assign bus.w_load = w_load_q;
  assign bus.sa_clear = sa_clear_q;
  assign bus.sa_en = sa_en_q;
  assign bus.x_valid = x_valid_q;
  assign bus.x_step = step;
  assign bus.tile_idx = tile_q;
  assign bus.y_valid = y_valid_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_sa_tile_sequencer.sv
// tb_sa_tile_sequencer: directed vector table plus multi-cycle sequences for the tile sequencer
module tb_sa_tile_sequencer;
  typedef struct {
    logic        sv;
    logic [4:0]  nt;
    logic        yr;
    logic        ab;
    logic [16:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sa_tile_sequencer_if #(.TW(5), .SW(4)) bus();
  sa_tile_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int vectors = 0, miscompares = 0;
  int n_wl, n_cl, n_en, n_yv, n_dn, last_ti, c, stall;
  logic stall_now;
  vec_t tbl[16];
  function automatic logic [16:0] ex(input logic sr, bz, wl, cl, en, xv, yv, dn, input int xs, ti);
    return {sr, bz, wl, cl, en, xv, yv, dn, 4'(xs), 5'(ti)};
  endfunction
  logic [16:0] idle_o;
  function automatic logic [16:0] obs();
    return {bus.start_ready, bus.busy, bus.w_load, bus.sa_clear, bus.sa_en, bus.x_valid,
            bus.y_valid, bus.done, bus.x_step, bus.tile_idx};
  endfunction
  task automatic chk(input string nm, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    n_wl += int'(bus.w_load);
    n_cl += int'(bus.sa_clear);
    n_en += int'(bus.sa_en);
    n_yv += int'(bus.y_valid);
    n_dn += int'(bus.done);
    if (bus.y_valid) last_ti = int'(bus.tile_idx);
  endtask
  task automatic clr();
    n_wl = 0; n_cl = 0; n_en = 0; n_yv = 0; n_dn = 0; last_ti = -1;
  endtask
  task automatic run_to_done(input int bound, output int cnt);
    cnt = 0;
    while (!bus.done && cnt < bound) begin
      tick();
      cnt++;
    end
    chk("done reached", int'(bus.done), 1);
    tick();
  endtask
  initial begin
    idle_o = ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.start_valid = 0; bus.num_tiles = 0; bus.abort = 0; bus.y_ready = 0;
    clr();
    tick(); tick();
    chk("reset state", int'(obs()), int'(idle_o));
    rst_n = 1;
    // async reset in the middle of STREAM
    bus.num_tiles = 2; bus.y_ready = 1; bus.start_valid = 1;
    tick();
    bus.start_valid = 0;
    repeat (5) tick();
    chk("t1 in stream", int'(bus.sa_en), 1);
    #3 rst_n = 0;
    #1 chk("t1 async reset", int'(obs()), int'(idle_o));
    tick();
    rst_n = 1;
    // single-tile job timeline, cycle 0 = accept
    tbl[0] = '{1'b1, 5'd1, 1'b1, 1'b0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1] = '{1'b0, 5'd1, 1'b1, 1'b0, ex(0, 1, 1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2] = '{1'b0, 5'd1, 1'b1, 1'b0, ex(0, 1, 0, 1, 0, 0, 0, 0, 0, 0)};
    for (int k = 3; k <= 12; k++)
      tbl[k] = '{1'b0, 5'd1, 1'b1, 1'b0, ex(0, 1, 0, 0, 1, k < 10, 0, 0, k - 3, 0)};
    tbl[13] = '{1'b0, 5'd1, 1'b1, 1'b0, ex(0, 1, 0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[14] = '{1'b0, 5'd1, 1'b1, 1'b0, ex(0, 1, 0, 0, 0, 0, 0, 1, 0, 0)};
    tbl[15] = '{1'b0, 5'd1, 1'b1, 1'b0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 16; i++) begin
      bus.start_valid = tbl[i].sv; bus.num_tiles = tbl[i].nt;
      bus.y_ready = tbl[i].yr; bus.abort = tbl[i].ab;
      chk($sformatf("t2 cycle %0d", i), int'(obs()), int'(tbl[i].exp));
      tick();
    end
    // 3 tiles, consumer stalls 5 cycles on tile 1
    clr(); stall = 0;
    bus.num_tiles = 3; bus.y_ready = 1; bus.start_valid = 1;
    tick();
    c = 1;
    bus.start_valid = 0;
    while (!bus.done && c < 200) begin
      stall_now = bus.y_valid && bus.tile_idx == 5'd1 && stall < 5;
      bus.y_ready = !stall_now;
      if (stall_now) begin
        chk("t3 stall hold", int'(obs()), int'(ex(0, 1, 0, 0, 0, 0, 1, 0, 0, 1)));
        stall++;
      end
      tick();
      c++;
    end
    chk("t3 done cycle", c, 43);
    chk("t3 stall cycles", stall, 5);
    chk("t3 w_load total", n_wl, 1);
    chk("t3 sa_clear total", n_cl, 3);
    chk("t3 done total", n_dn, 1);
    chk("t3 y_valid cycles", n_yv, 8);
    bus.y_ready = 1;
    tick();
    // abort at x_step 4, then immediate restart
    clr();
    bus.num_tiles = 2; bus.start_valid = 1;
    tick();
    c = 1;
    bus.start_valid = 0;
    while (!(bus.sa_en && bus.x_step == 4'd4) && c < 50) begin
      tick();
      c++;
    end
    chk("t4 abort cycle", c, 7);
    bus.abort = 1;
    tick();
    bus.abort = 0;
    chk("t4 idle after abort", int'(obs()), int'(idle_o));
    chk("t4 no y_valid", n_yv, 0);
    chk("t4 no done", n_dn, 0);
    bus.num_tiles = 1; bus.start_valid = 1;
    tick();
    bus.start_valid = 0;
    chk("t4 restart w_load", int'(obs()), int'(ex(0, 1, 1, 0, 0, 0, 0, 0, 0, 0)));
    run_to_done(40, c);
    chk("t4 restart done", n_dn, 1);
    // abort wins over a handshake in OUTPUT
    clr();
    bus.y_ready = 0; bus.num_tiles = 2; bus.start_valid = 1;
    tick();
    c = 1;
    bus.start_valid = 0;
    while (!bus.y_valid && c < 50) begin
      tick();
      c++;
    end
    chk("t4b first y_valid cycle", c, 13);
    bus.y_ready = 1; bus.abort = 1;
    tick();
    bus.abort = 0;
    chk("t4b idle after abort", int'(obs()), int'(idle_o));
    repeat (3) tick();
    chk("t4b no done", n_dn, 0);
    chk("t4b one clear", n_cl, 1);
    // start_valid while busy is ignored
    clr();
    bus.num_tiles = 2; bus.start_valid = 1;
    tick();
    bus.start_valid = 0;
    repeat (3) tick();
    bus.start_valid = 1; bus.num_tiles = 9;
    chk("t5 start_ready busy", int'(bus.start_ready), 0);
    tick();
    bus.start_valid = 0; bus.num_tiles = 7;
    run_to_done(100, c);
    chk("t5 done cycle", 5 + c, 26);
    chk("t5 sa_clear total", n_cl, 2);
    chk("t5 y_valid total", n_yv, 2);
    chk("t5 w_load total", n_wl, 1);
    chk("t5 back to idle", int'(obs()), int'(idle_o));
    // zero tiles, then saturation of 31 to 16
    clr();
    bus.num_tiles = 0; bus.start_valid = 1;
    tick();
    bus.start_valid = 0;
    chk("t6 zero done", int'(obs()), int'(ex(0, 1, 0, 0, 0, 0, 0, 1, 0, 0)));
    tick();
    chk("t6 zero idle", int'(obs()), int'(idle_o));
    chk("t6 zero no strobes", n_wl + n_cl + n_en, 0);
    clr();
    bus.num_tiles = 31; bus.start_valid = 1;
    tick();
    bus.start_valid = 0;
    run_to_done(400, c);
    chk("t6 sat done cycle", 1 + c, 194);
    chk("t6 sat sa_clear", n_cl, 16);
    chk("t6 sat y_valid", n_yv, 16);
    chk("t6 sat last tile", last_ti, 15);
    chk("t6 sat idle", int'(obs()), int'(idle_o));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
